// File: rtl/motor_dir_sequencer.sv
// Single-channel motor driver controller: EN PWM generation, braked direction
// reversal (stop detect via tach, dead time, DIR flip) and tach period measurement.
module motor_dir_sequencer #(
  parameter int PWM_TOP     = 3999,
  parameter int DEAD_CYCLES = 100000,
  parameter int STOP_CYCLES = 2000000,
  parameter int MAX_WAIT    = 50000000,
  parameter int TACH_W      = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_in,
  input  logic              dir_in,
  input  logic [11:0]       duty_in,
  input  logic              sa_in,
  output logic              en_out,
  output logic              dir_out,
  output logic [1:0]        state_out,
  output logic              busy,
  output logic [TACH_W-1:0] tach_period,
  output logic              tach_valid,
  output logic              timeout_flag
);

  localparam int PWM_W  = $clog2(PWM_TOP + 1);
  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
  localparam int STOP_W = $clog2(STOP_CYCLES + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_WAIT = 2'd2,
    DEAD      = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic [11:0]         duty_q, duty_d;
  logic                en_q, en_d;
  logic                dir_q, dir_d;
  logic                busy_q, busy_d;
  logic [STOP_W-1:0]   stop_cnt_q, stop_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DEAD_W-1:0]   dead_cnt_q, dead_cnt_d;
  logic                sa_s1_q, sa_s2_q, sa_s3_q;
  logic [TACH_W-1:0]   per_cnt_q, per_cnt_d;
  logic [TACH_W-1:0]   tach_period_q, tach_period_d;
  logic                tach_valid_q, tach_valid_d;
  logic                timeout_q, timeout_d;

  logic sa_rise;
  logic stop_hit;
  logic wait_hit;

  assign sa_rise  = sa_s2_q & ~sa_s3_q;
  assign stop_hit = (stop_cnt_q == STOP_W'(STOP_CYCLES - 1));
  assign wait_hit = (wait_cnt_q == WAIT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pwm_cnt_q     <= '0;
      duty_q        <= '0;
      en_q          <= 1'b0;
      dir_q         <= 1'b0;
      busy_q        <= 1'b0;
      stop_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      dead_cnt_q    <= '0;
      sa_s1_q       <= 1'b0;
      sa_s2_q       <= 1'b0;
      sa_s3_q       <= 1'b0;
      per_cnt_q     <= '0;
      tach_period_q <= '0;
      tach_valid_q  <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pwm_cnt_q     <= pwm_cnt_d;
      duty_q        <= duty_d;
      en_q          <= en_d;
      dir_q         <= dir_d;
      busy_q        <= busy_d;
      stop_cnt_q    <= stop_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      dead_cnt_q    <= dead_cnt_d;
      sa_s1_q       <= sa_in;
      sa_s2_q       <= sa_s1_q;
      sa_s3_q       <= sa_s2_q;
      per_cnt_q     <= per_cnt_d;
      tach_period_q <= tach_period_d;
      tach_valid_q  <= tach_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  // Priorities: disable beats reversal in RUN; abort beats stop beats timeout in STOP_WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable_in) state_d = (dir_in == dir_q) ? RUN : STOP_WAIT;
      end
      RUN: begin
        if (!enable_in)          state_d = IDLE;
        else if (dir_in != dir_q) state_d = STOP_WAIT;
      end
      STOP_WAIT: begin
        if (dir_in == dir_q) state_d = IDLE;
        else if (stop_hit)   state_d = DEAD;
        else if (wait_hit)   state_d = DEAD;
      end
      DEAD: begin
        if (dead_cnt_q == DEAD_W'(DEAD_CYCLES - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pwm_cnt_d  = '0;
    duty_d     = duty_q;
    en_d       = 1'b0;
    stop_cnt_d = '0;
    wait_cnt_d = '0;
    dead_cnt_d = '0;
    dir_d      = dir_q;
    busy_d     = (state_d == STOP_WAIT) || (state_d == DEAD);
    timeout_d  = timeout_q;

    if (state_q == RUN) begin
      if (pwm_cnt_q == '0) duty_d = duty_in;
      if (state_d == RUN) begin
        pwm_cnt_d = (pwm_cnt_q == PWM_W'(PWM_TOP)) ? '0 : pwm_cnt_q + PWM_W'(1);
        en_d      = (32'(pwm_cnt_q) < 32'(duty_d));
      end
    end

    if (state_q == STOP_WAIT) begin
      if (state_d == STOP_WAIT) begin
        stop_cnt_d = sa_rise ? '0 : stop_cnt_q + STOP_W'(1);
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end else if (state_d == DEAD) begin
        dir_d = dir_in;
        if (!stop_hit) timeout_d = 1'b1;
      end
    end

    if (state_q == DEAD && state_d == DEAD) dead_cnt_d = dead_cnt_q + DEAD_W'(1);

    // All-ones in per_cnt means no edge for at least that long (stalled).
    per_cnt_d     = (&per_cnt_q) ? per_cnt_q : per_cnt_q + TACH_W'(1);
    tach_period_d = tach_period_q;
    tach_valid_d  = sa_rise;
    if (sa_rise) begin
      per_cnt_d     = TACH_W'(1);
      tach_period_d = per_cnt_q;
    end
  end

  assign en_out       = en_q;
  assign dir_out      = dir_q;
  assign state_out    = state_q;
  assign busy         = busy_q;
  assign tach_period  = tach_period_q;
  assign tach_valid   = tach_valid_q;
  assign timeout_flag = timeout_q;

endmodule

// File: tb/tb_motor_dir_sequencer.sv
// Bench for motor_dir_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the controller.
module tb_motor_dir_sequencer;

  localparam int PWM_TOP     = 9;
  localparam int DEAD_CYCLES = 5;
  localparam int STOP_CYCLES = 20;
  localparam int MAX_WAIT    = 100;
  localparam int TACH_W      = 8;
  localparam int TACH_MAX    = (1 << TACH_W) - 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_SW   = 2;
  localparam int M_DEAD = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable_in;
  logic              dir_in;
  logic [11:0]       duty_in;
  logic              sa_in;
  logic              en_out;
  logic              dir_out;
  logic [1:0]        state_out;
  logic              busy;
  logic [TACH_W-1:0] tach_period;
  logic              tach_valid;
  logic              timeout_flag;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  int          m_mode;
  int          m_age;
  int          m_quiet;
  int          m_since;
  int          m_tp;
  logic        m_en, m_dir, m_busy, m_tv, m_to;
  logic [11:0] m_duty;
  logic        sa_h [3];

  motor_dir_sequencer #(
    .PWM_TOP    (PWM_TOP),
    .DEAD_CYCLES(DEAD_CYCLES),
    .STOP_CYCLES(STOP_CYCLES),
    .MAX_WAIT   (MAX_WAIT),
    .TACH_W     (TACH_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable_in   (enable_in),
    .dir_in      (dir_in),
    .duty_in     (duty_in),
    .sa_in       (sa_in),
    .en_out      (en_out),
    .dir_out     (dir_out),
    .state_out   (state_out),
    .busy        (busy),
    .tach_period (tach_period),
    .tach_valid  (tach_valid),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock of the controller as described behaviourally: an SA level seen at
  // one edge acts as a rising-edge event two edges later.
  task automatic model_edge();
    logic rise;
    int   nxt;
    int   pos;
    rise     = sa_h[1] & ~sa_h[2];
    sa_h[2]  = sa_h[1];
    sa_h[1]  = sa_h[0];
    sa_h[0]  = sa_in;
    if (reset) begin
      m_mode = M_IDLE; m_age = 0; m_quiet = 0; m_since = 0; m_tp = 0;
      m_en = 0; m_dir = 0; m_busy = 0; m_tv = 0; m_to = 0; m_duty = 0;
      sa_h[0] = 0; sa_h[1] = 0; sa_h[2] = 0;
      return;
    end
    m_tv = rise;
    if (rise) begin
      m_tp    = m_since;
      m_since = 1;
    end else if (m_since < TACH_MAX) begin
      m_since++;
    end

    nxt  = m_mode;
    m_en = 0;
    case (m_mode)
      M_IDLE: if (enable_in) nxt = (dir_in == m_dir) ? M_RUN : M_SW;
      M_RUN: begin
        if (!enable_in) nxt = M_IDLE;
        else if (dir_in != m_dir) nxt = M_SW;
        pos = m_age % (PWM_TOP + 1);
        if (pos == 0) m_duty = duty_in;
        if (nxt == M_RUN) m_en = (pos < int'(m_duty));
      end
      M_SW: begin
        if (dir_in == m_dir) nxt = M_IDLE;
        else if (m_quiet == STOP_CYCLES - 1) begin
          nxt = M_DEAD; m_dir = dir_in;
        end else if (m_age == MAX_WAIT - 1) begin
          nxt = M_DEAD; m_dir = dir_in; m_to = 1;
        end
        m_quiet = rise ? 0 : m_quiet + 1;
      end
      default: if (m_age == DEAD_CYCLES - 1) nxt = M_IDLE;
    endcase
    if (nxt != m_mode) begin
      m_age = 0; m_quiet = 0;
    end else begin
      m_age++;
    end
    m_busy = (nxt == M_SW) || (nxt == M_DEAD);
    m_mode = nxt;
  endtask

  task automatic check_all();
    chk("state",        state_out,    m_mode);
    chk("en_out",       en_out,       m_en);
    chk("dir_out",      dir_out,      m_dir);
    chk("busy",         busy,         m_busy);
    chk("tach_valid",   tach_valid,   m_tv);
    chk("tach_period",  tach_period,  m_tp);
    chk("timeout_flag", timeout_flag, m_to);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic got;
    sa_h[0] = 0; sa_h[1] = 0; sa_h[2] = 0;
    reset = 1; enable_in = 0; dir_in = 0; duty_in = 0; sa_in = 0;
    steps(3);
    chk("reset_state", state_out, 0);
    chk("reset_period", tach_period, 0);

    // Run forward at duty 3, then full duty
    reset = 0; enable_in = 1; dir_in = 0; duty_in = 12'd3;
    steps(30);
    duty_in = 12'd12;
    steps(25);

    // Mid-period duty change
    duty_in = 12'd3;
    steps(24);
    duty_in = 12'd7;
    steps(25);

    // Reversal with a silent tach
    dir_in = 1;
    steps(40);

    // Reversal with a spinning tach: ends by timeout
    dir_in = 0;
    for (int i = 0; i < 130; i++) begin
      if (i % 8 == 0) sa_in = ~sa_in;
      step();
    end
    chk("timeout_set", timeout_flag, 1);
    sa_in = 0;
    steps(10);

    // Abort a reversal
    dir_in = 1;
    steps(10);
    dir_in = 0;
    steps(10);

    // Tach measurement, periodic then stalled
    enable_in = 0;
    for (int p = 0; p < 4; p++) begin
      sa_in = 1; steps(5);
      sa_in = 0; steps(32);
    end
    chk("tach_37", tach_period, 37);
    steps(300);
    sa_in = 1;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      got = tach_valid;
    end
    chk("stall_valid_seen", got, 1);
    chk("stall_period", tach_period, TACH_MAX);
    sa_in = 0;

    // Reset in the middle of DEAD
    enable_in = 1; dir_in = !m_dir;
    for (int i = 0; i < 60 && m_mode != M_DEAD; i++) step();
    steps(2);
    reset = 1;
    step();
    chk("rst_en", en_out, 0);
    chk("rst_dir", dir_out, 0);
    chk("rst_state", state_out, 0);
    chk("rst_timeout", timeout_flag, 0);
    reset = 0;

    // Random traffic: quiet tach, then busy tach
    for (int i = 0; i < 1400; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      enable_in = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) dir_in = ~dir_in;
      if ($urandom_range(0, 19) == 0) duty_in = 12'($urandom_range(0, 12));
      if (i < 700) begin
        if ($urandom_range(0, 59) == 0) sa_in = ~sa_in;
      end else begin
        if ($urandom_range(0, 3) == 0) sa_in = ~sa_in;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
